// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared defaults for the SPI slave block.
//   DATA_W_DEF    : default frame length in bits
//   CNT_W_DEF     : default bit-counter width (2**CNT_W_DEF >= DATA_W_DEF)
//   BIT_ORDER_MSB : value of the bit-order select meaning MSB-first
//   BIT_ORDER_LSB : value of the bit-order select meaning LSB-first
// ---------------------------------------------------------------------------
package spi_pkg;
    localparam int   DATA_W_DEF    = 16;
    localparam int   CNT_W_DEF     = 4;
    localparam logic BIT_ORDER_MSB = 1'b1;
    localparam logic BIT_ORDER_LSB = 1'b0;
endpackage

// File: rtl/spi_shift_reg.sv
// ---------------------------------------------------------------------------
// spi_shift_reg
// Bidirectional shift register with parallel load and serial input.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : synchronous reset, active-low (clears the register)
//   i_load       : parallel load of i_load_val (wins over i_shift)
//   i_load_val   : W-bit parallel load value
//   i_shift      : shift by one position
//   i_msb_first  : 1 = shift toward the MSB (serial in at bit 0),
//                  0 = shift toward the LSB (serial in at bit W-1)
//   i_ser_in     : serial input bit
//   o_q          : current register contents
// ---------------------------------------------------------------------------
module spi_shift_reg #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_shift,
    input  logic         i_msb_first,
    input  logic         i_ser_in,
    output logic [W-1:0] o_q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (i_load) begin
            q_d = i_load_val;
        end else if (i_shift) begin
            if (i_msb_first) begin
                q_d = {q_q[W-2:0], i_ser_in};
            end else begin
                q_d = {i_ser_in, q_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/spi_slave16.sv
// ---------------------------------------------------------------------------
// spi_slave16
// SPI mode-0 slave, full duplex, clocked directly by the serial clock.
// Receives a DATA_W-bit word on MOSI while shifting out a parallel-loaded
// word on MISO, in MSB-first or LSB-first order.
// Ports:
//   i_sck   : SPI serial clock, the only clock (rising edge)
//   i_rst   : synchronous reset, active-low
//   i_ss    : slave select, active-low
//   i_mosi  : serial data in, sampled on rising i_sck
//   i_msb   : bit order, 1 = MSB-first; latched when the tx word is loaded
//   i_data  : word to transmit; loaded while idle or at frame end
//   o_miso  : serial data out (combinational from tx register and i_ss)
//   o_done  : one-cycle pulse after the last bit of a frame
//   o_data  : last complete received word
// Output handshake: o_done is a valid-only strobe with no ready; o_data is
// valid in the cycle o_done is high and holds until the next frame ends.
// Build option: define SPI_SLAVE_MISO_TRISTATE_EN to float o_miso while
// i_ss is high; otherwise o_miso drives 0 when deselected.
// ---------------------------------------------------------------------------
module spi_slave16
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_sck,
    input  logic              i_rst,
    input  logic              i_ss,
    input  logic              i_mosi,
    input  logic              i_msb,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_miso,
    output logic              o_done,
    output logic [DATA_W-1:0] o_data
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              msb_q, msb_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              active;
    logic              last_bit;
    logic              tx_load;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_word;
    logic              tx_bit;

    assign active   = ~i_ss;
    assign last_bit = active && (cnt_q == LAST_CNT);
    // The tx word (and its bit order) is reloaded on every idle edge and on
    // the final edge of a frame, so back-to-back frames need no deselect.
    assign tx_load  = ~active | last_bit;

    // Received word as it will look after the current edge, including the
    // bit on i_mosi right now; captured into o_data on the final edge.
    always_comb begin
        if (msb_q == BIT_ORDER_MSB) begin
            rx_word = {rx_q[DATA_W-2:0], i_mosi};
        end else begin
            rx_word = {i_mosi, rx_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        msb_d  = msb_q;
        done_d = 1'b0;
        data_d = data_q;
        if (!active || last_bit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (tx_load) begin
            msb_d = i_msb;
        end
        if (last_bit) begin
            done_d = 1'b1;
            data_d = rx_word;
        end
    end

    always_ff @(posedge i_sck) begin
        if (!i_rst) begin
            cnt_q  <= '0;
            msb_q  <= BIT_ORDER_MSB;
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            msb_q  <= msb_d;
            done_q <= done_d;
            data_q <= data_d;
        end
    end

    spi_shift_reg #(.W(DATA_W)) u_rx (
        .i_clk       (i_sck),
        .i_rst       (i_rst),
        .i_load      (1'b0),
        .i_load_val  ({DATA_W{1'b0}}),
        .i_shift     (active),
        .i_msb_first (msb_q),
        .i_ser_in    (i_mosi),
        .o_q         (rx_q)
    );

    spi_shift_reg #(.W(DATA_W)) u_tx (
        .i_clk       (i_sck),
        .i_rst       (i_rst),
        .i_load      (tx_load),
        .i_load_val  (i_data),
        .i_shift     (active),
        .i_msb_first (msb_q),
        .i_ser_in    (1'b0),
        .o_q         (tx_q)
    );

    assign tx_bit = (msb_q == BIT_ORDER_MSB) ? tx_q[DATA_W-1] : tx_q[0];

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign o_miso = i_ss ? 1'bz : tx_bit;
`else
    assign o_miso = i_ss ? 1'b0 : tx_bit;
`endif

    assign o_done = done_q;
    assign o_data = data_q;

endmodule

// File: tb/tb_spi_slave16.sv
// ---------------------------------------------------------------------------
// tb_spi_slave16
// Bench for spi_slave16: a mode-0 master model drives MOSI on the falling
// edge and captures MISO before the next rising edge. Expected received
// words go into exp_q when a frame is started and are popped by a monitor
// whenever o_done is seen.
// ---------------------------------------------------------------------------
module tb_spi_slave16;

    localparam int W = 16;

    logic         i_sck;
    logic         i_rst;
    logic         i_ss;
    logic         i_mosi;
    logic         i_msb;
    logic [W-1:0] i_data;
    logic         o_miso;
    logic         o_done;
    logic [W-1:0] o_data;

    spi_slave16 dut (
        .i_sck  (i_sck),
        .i_rst  (i_rst),
        .i_ss   (i_ss),
        .i_mosi (i_mosi),
        .i_msb  (i_msb),
        .i_data (i_data),
        .o_miso (o_miso),
        .o_done (o_done),
        .o_data (o_data)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_sck = 1'b0;
        forever #5 i_sck = ~i_sck;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int n_frames = 0;
    int cyc      = 0;
    int last_done_cyc = 0;
    int last_gap = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every o_done pulse must match the oldest expected word.
    always @(negedge i_sck) begin
        cyc++;
        if (o_done === 1'b1) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got o_done=1 o_data=0x%0h required no pulse", o_data);
            end else begin
                check("o_data", {16'd0, o_data}, {16'd0, exp_q.pop_front()});
            end
            last_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
            done_cnt++;
        end
        prev_done = (o_done === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_sck);
            i_ss   = 1'b1;
            i_mosi = 1'b0;
        end
    endtask

    // Shift n bits of w with slave selected; optionally change i_data/i_msb
    // at bit index mid_at. Returns the bits captured from MISO.
    task automatic drive_bits(input logic [W-1:0] w, input logic msb, input int n,
                              input int mid_at, input logic [W-1:0] mid_data,
                              input logic mid_msb, output logic [W-1:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_sck);
            i_rst  = 1'b1;
            i_ss   = 1'b0;
            i_mosi = msb ? w[W-1-i] : w[i];
            if (i == mid_at) begin
                i_data = mid_data;
                i_msb  = mid_msb;
            end
            #1;
            cap = msb ? {cap[W-2:0], o_miso} : {o_miso, cap[W-1:1]};
        end
    endtask

    task automatic full_frame(input string name, input logic [W-1:0] w, input logic msb,
                              input logic [W-1:0] exp_tx, input int mid_at,
                              input logic [W-1:0] mid_data, input logic mid_msb);
        logic [W-1:0] cap;
        exp_q.push_back(w);
        n_frames++;
        drive_bits(w, msb, W, mid_at, mid_data, mid_msb, cap);
        check(name, {16'd0, cap}, {16'd0, exp_tx});
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [W-1:0] rx;
        logic         msb;
        logic [W-1:0] tx;
    } vec_t;

    vec_t vecs[6];
    logic idle_miso;

    initial begin
        logic [W-1:0] cap;
        int d0;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        idle_miso = 1'bz;
`else
        idle_miso = 1'b0;
`endif
        vecs[0] = '{rx: 16'h428A, msb: 1'b1, tx: 16'h45FA};
        vecs[1] = '{rx: 16'h428A, msb: 1'b0, tx: 16'h1234};
        vecs[2] = '{rx: 16'hFFFF, msb: 1'b1, tx: 16'h0000};
        vecs[3] = '{rx: 16'h0001, msb: 1'b0, tx: 16'h8000};
        vecs[4] = '{rx: 16'($urandom_range(0, 65535)), msb: 1'b1, tx: 16'($urandom_range(0, 65535))};
        vecs[5] = '{rx: 16'($urandom_range(0, 65535)), msb: 1'b0, tx: 16'($urandom_range(0, 65535))};

        i_rst  = 1'b0;
        i_ss   = 1'b1;
        i_mosi = 1'b0;
        i_msb  = 1'b1;
        i_data = '0;

        // reset state
        repeat (3) @(negedge i_sck);
        check("reset_o_data", {16'd0, o_data}, 32'd0);
        check("reset_o_done", {31'd0, o_done}, 32'd0);
        check("reset_idle_miso", {31'd0, o_miso}, {31'd0, idle_miso});
        i_rst = 1'b1;

        // table-driven single frames
        for (int v = 0; v < 6; v++) begin
            i_data = vecs[v].tx;
            i_msb  = vecs[v].msb;
            idle(2);
            full_frame("miso_word", vecs[v].rx, vecs[v].msb, vecs[v].tx, -1, '0, vecs[v].msb);
            idle(2);
            check("o_data_held", {16'd0, o_data}, {16'd0, vecs[v].rx});
            check("idle_miso", {31'd0, o_miso}, {31'd0, idle_miso});
            check("idle_done", {31'd0, o_done}, 32'd0);
        end

        // mid-frame bit-order change must not affect the current frame
        i_data = 16'hC3A5;
        i_msb  = 1'b1;
        idle(2);
        full_frame("msb_flip_miso", 16'h6B1D, 1'b1, 16'hC3A5, 5, 16'hC3A5, 1'b0);
        idle(2);
        i_msb = 1'b1;

        // back-to-back frames without deselect
        i_data = 16'h3C3C;
        idle(2);
        d0 = done_cnt;
        full_frame("b2b_miso_1", 16'hA5A5, 1'b1, 16'h3C3C, 3, 16'h00FF, 1'b1);
        full_frame("b2b_miso_2", 16'h0F0F, 1'b1, 16'h00FF, -1, '0, 1'b1);
        idle(3);
        check("b2b_done_count", done_cnt - d0, 32'd2);
        check("b2b_done_gap", last_gap, 32'd16);

        // abort after 7 bits
        i_data = 16'h1111;
        idle(2);
        d0 = done_cnt;
        drive_bits(16'h7E3C, 1'b1, 7, -1, '0, 1'b1, cap);
        i_data = 16'h2222;
        idle(4);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_o_data", {16'd0, o_data}, 32'h0F0F);
        full_frame("post_abort_miso", 16'hBEEF, 1'b1, 16'h2222, -1, '0, 1'b1);
        idle(2);
        check("post_abort_o_data", {16'd0, o_data}, 32'hBEEF);

        // reset mid-frame, then a frame right out of reset with select held
        i_data = 16'h7777;
        idle(2);
        drive_bits(16'hFFFF, 1'b1, 8, -1, '0, 1'b1, cap);
        @(negedge i_sck);
        i_rst = 1'b0;
        @(negedge i_sck);
        check("midreset_o_data", {16'd0, o_data}, 32'd0);
        check("midreset_o_done", {31'd0, o_done}, 32'd0);
        full_frame("post_reset_miso", 16'h1357, 1'b1, 16'h0000, -1, '0, 1'b1);
        idle(2);
        check("post_reset_o_data", {16'd0, o_data}, 32'h1357);

        // idle line stays quiet
        idle(5);
        check("final_idle_miso", {31'd0, o_miso}, {31'd0, idle_miso});
        check("final_idle_done", {31'd0, o_done}, 32'd0);
        check("all_frames_done", done_cnt, n_frames);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave16.md
Name: spi_slave16

Overview:
16-bit SPI slave, mode 0 (CPOL=0, CPHA=0), full duplex, clocked directly by the SPI serial clock.
- Receives one word on MOSI while transmitting a parallel-loaded word on MISO.
- Selectable MSB-first or LSB-first bit order.
- Signals frame completion with a one-cycle done pulse and a held parallel output word.
- Front end between an external SPI master and on-chip register/data logic, e.g. the SHA-256 core loader.

Parameters:
DATA_W, 16, frame length in bits; all data ports are DATA_W wide.
CNT_W, 4, bit-counter width; must satisfy 2^CNT_W >= DATA_W.

Ports:
i_sck  in  1  SPI serial clock; the only clock; all state updates on rising edge
i_rst  in  1  reset, synchronous to i_sck, active-low
i_ss  in  1  slave select, active-low
i_mosi  in  1  master-out serial data, sampled on i_sck rising edge
i_msb  in  1  1 = MSB-first, 0 = LSB-first; latched at frame load
i_data  in  DATA_W  word to transmit; loaded while idle or at frame end
o_miso  out  1  slave-out serial data
o_done  out  1  one-cycle pulse after the last bit of a frame
o_data  out  DATA_W  last complete received word, held until the next frame completes

Behaviour:
- Reset (i_rst=0 at a rising i_sck): bit counter=0, rx shift=0, tx shift=0, o_data=0, o_done=0, latched order=MSB-first. Reset has priority over everything else.
- Idle (i_ss=1) on each rising edge:
  - tx shift <= i_data; latched order <= i_msb.
  - Counter <= 0; rx shift unchanged; o_done <= 0.
- Active (i_ss=0) on each rising edge:
  - MSB-first: rx <= {rx[DATA_W-2:0], i_mosi}; tx <= {tx[DATA_W-2:0], 0}.
  - LSB-first: rx <= {i_mosi, rx[DATA_W-1:1]}; tx <= {0, tx[DATA_W-1:1]}.
  - Counter increments.
- o_miso is combinational:
  - i_ss=0: tx[DATA_W-1] when MSB-first, tx[0] when LSB-first.
  - i_ss=1: 0.
  - First bit is valid as soon as i_ss falls. Each later bit changes just after the rising edge, so the master sees it stable before its next rising-edge sample.
- Frame end, on the rising edge where counter==DATA_W-1 and i_ss=0:
  - o_data <= the fully assembled word, including the current i_mosi bit.
  - o_done <= 1 for exactly one i_sck cycle.
  - Counter wraps to 0.
  - tx <= i_data and order <= i_msb, so back-to-back frames need no i_ss deassertion.
- o_done is 0 on every other edge.
- Abort: i_ss rises mid-frame → partial word discarded, counter cleared, no o_done, o_data unchanged.
- Extra clocks after a frame with i_ss still low start the next frame.
- i_msb changes mid-frame are ignored.
- Latency: o_data/o_done valid one cycle after the DATA_W-th rising edge.

Optional Feature:
SPI_SLAVE_MISO_TRISTATE_EN
- Defined: o_miso = high-Z while i_ss=1, allowing a shared MISO line.
- Undefined: o_miso drives 0 while i_ss=1.
- Behaviour with i_ss=0 is identical in both builds.

Decomposition:
- Package spi_pkg: DATA_W/CNT_W defaults and localparams BIT_ORDER_MSB=1, BIT_ORDER_LSB=0.
- One sub-module, spi_shift_reg: parameterised bidirectional shift register with parallel load, serial in and serial out, direction select.
- Instantiated twice: rx (serial in) and tx (parallel load).

Test Plan:
- MSB-first basic: reset, i_ss low, master shifts 0x428A (drive on falling edge, sample on rising edge), i_data=0x45FA → o_data=0x428A, single o_done pulse, master captures 0x45FA.
- LSB-first: i_msb=0, send 0x428A LSB-first, i_data=0x1234 → o_data=0x428A, master (LSB-first) captures 0x1234.
- Back-to-back: two frames 0xA5A5 then 0x0F0F with i_ss held low, i_data changed to 0x00FF before the second load → two o_done pulses 16 cycles apart, o_data 0xA5A5 then 0x0F0F, second MISO word 0x00FF.
- Abort: i_ss raised after 7 bits, then a full frame 0xBEEF → no o_done after the partial frame, o_data=0xBEEF after the full one.
- Reset mid-frame: i_rst=0 after 8 bits → o_data=0, o_done=0, counter=0; the next full frame 0x1357 is received correctly.
- Idle MISO: i_ss=1 → o_miso=0 (or high-Z with SPI_SLAVE_MISO_TRISTATE_EN), o_done stays 0.
